oh_enc_pipe: RTL and testbench
==============================

# oh_enc_pipe

Registered one-hot-to-binary encoder with valid/ready flow control. It is the return leg for the leading-zero/priority detectors: it takes a one-hot (or arbitrary) vector and produces the binary index of its most-significant set bit, using the same MSB-first priority convention as `lzd`/`pri`. A two-entry skid buffer lets it sit between pipeline stages that both apply backpressure, without a combinational ready path.

## Interface
Parameters:
- `W`, 16: input vector width; legal range W ≥ 2.
- `IW`, `$clog2(W)`: index width; derived, never overridden.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `i_in_vld`  in  1  input vector valid.
- `i_in_x`  in  W  input vector.
- `o_in_rdy`  out  1  block can accept input; driven directly from a flop.
- `o_out_vld`  out  1  output valid.
- `o_out_idx`  out  IW  index of the MSB-most set bit of the accepted vector.
- `o_out_zero`  out  1  accepted vector was all-zero; `o_out_idx` is 0.
- `o_out_err`  out  1  accepted vector had more than one bit set. Present only with `OH_ENC_PIPE_CHECK_EN`.
- `i_out_rdy`  in  1  downstream accepts output.

## Operation
- Input handshake fires when `i_in_vld & o_in_rdy`. Output handshake fires when `o_out_vld & i_out_rdy`.
- Encode function: `idx` is the highest i with `i_in_x[i]=1`. `zero = ~|i_in_x`. `err = more than one bit set`.
- Encoding is done combinationally on the input side. Only the results (`idx`, `zero`, and `err` when enabled) are stored, never the raw vector.
- Storage: main register M drives the outputs; skid register S holds overflow.
- States:
  - EMPTY: M and S invalid.
  - ONE: M valid.
  - FULL: M and S valid.
- Transitions, where in = input fire and out = output fire:
  - EMPTY, in: M←enc, go to ONE.
  - ONE, in & ~out: S←enc, go to FULL.
  - ONE, in & out: M←enc, stay in ONE.
  - ONE, ~in & out: go to EMPTY.
  - FULL, out: M←S, go to ONE. No input can fire in FULL.
  - All other cases: hold.
- `o_in_rdy = (state != FULL)`, registered.
- `o_out_vld = (state != EMPTY)`.
- Data order is strict FIFO. No entry is dropped or duplicated.
- Output fields are stable while `o_out_vld & ~i_out_rdy`.

## Timing
- Latency: an input accepted in cycle N appears on the outputs in cycle N+1 if M was empty or draining.
- Throughput: one transfer per cycle sustained while `i_out_rdy=1`.
- `o_in_rdy` falls in the cycle after the entry that fills S is accepted. It rises in the cycle after the output fire in FULL.
- No combinational path from `i_out_rdy` to `o_in_rdy`. The only combinational path from input to output is none.
- Reset values:
  - state is EMPTY.
  - `o_out_vld=0`, `o_in_rdy=1`.
  - `o_out_idx=0`, `o_out_zero=0`, `o_out_err=0`.
- Reset asserted mid-transfer discards M and S contents. It takes priority over any same-cycle handshake.
- Simultaneous in/out in ONE is a pass-through with no bubble.
- The value of `i_in_x` is ignored when `i_in_vld=0`.

## Configuration
- Macro: `OH_ENC_PIPE_CHECK_EN`.
- Defined:
  - Multi-hot detection is built.
  - `o_out_err` port exists and is stored in M/S alongside `idx`.
  - `o_out_idx` still reports the MSB-most set bit.
- Undefined:
  - No `o_out_err` port and no error logic or storage.
  - Multi-hot inputs silently encode to the MSB-most set bit.

## Test plan
All scenarios use W=16, IW=4.
- Reset: hold `rst` for 2 cycles with `i_in_vld=1` -> `o_out_vld=0`, `o_in_rdy=1`, `o_out_idx=0` throughout. The first output appears only after the first accepted post-reset input.
- Single encode, `i_out_rdy=1`: `i_in_x=16'h0400` accepted in cycle N -> in cycle N+1, `o_out_vld=1`, `o_out_idx=10`, `o_out_zero=0`.
- Zero / multi-hot: `16'h0000` -> `idx=0`, `zero=1`. Then `16'h8001` -> `idx=15`, `zero=0`, and `err=1` when the macro is defined (absent otherwise).
- Backpressure:
  - Stimulus: `i_out_rdy=0`; offer `16'h0001`, `16'h0002`, `16'h0004` on consecutive cycles.
  - Required: the first two are accepted; `o_in_rdy` is 0 from the cycle after the second acceptance, and the third is held at the input.
  - Stimulus: raise `i_out_rdy`.
  - Required: outputs 0, 1, 2 in order, one per cycle once flowing.
- Streaming: 64 random one-hot vectors with `i_out_rdy=1` -> 64 outputs on consecutive cycles, indices matching in order, no bubbles.
- Reset mid-operation: reach FULL, then assert `rst` for 1 cycle -> next cycle `o_out_vld=0`, `o_in_rdy=1`; the stale entries never appear on the output.

Source files
------------

// File: rtl/oh_enc_pipe.sv
// rtl/oh_enc_pipe.sv - registered MSB-first one-hot encoder with two-entry skid buffer, optional OH_ENC_PIPE_CHECK_EN multi-hot flag
module oh_enc_pipe #(
    parameter int W  = 16,
    parameter int IW = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_in_vld,
    input  logic [W-1:0]  i_in_x,
    output logic          o_in_rdy,
    output logic          o_out_vld,
    output logic [IW-1:0] o_out_idx,
    output logic          o_out_zero,
`ifdef OH_ENC_PIPE_CHECK_EN
    output logic          o_out_err,
`endif
    input  logic          i_out_rdy
);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t        state, state_nxt;
    logic          in_rdy_q;
    logic          in_fire, out_fire;
    logic          load_m_enc, load_m_skid, load_s;
    logic [IW-1:0] enc_idx, m_idx, s_idx;
    logic          enc_zero, m_zero, s_zero;

    // Later (higher) set bits overwrite earlier ones, giving MSB-first priority.
    always_comb begin
        enc_idx = '0;
        for (int i = 0; i < W; i++) begin
            if (i_in_x[i]) enc_idx = IW'(i);
        end
    end

    assign enc_zero = ~|i_in_x;

`ifdef OH_ENC_PIPE_CHECK_EN
    logic enc_err, m_err, s_err;

    // Clearing the lowest set bit leaves something only when two or more were set.
    assign enc_err = |(i_in_x & (i_in_x - W'(1)));
`endif

    assign in_fire  = i_in_vld & in_rdy_q;
    assign out_fire = (state != EMPTY) & i_out_rdy;

    always_comb begin
        state_nxt   = state;
        load_m_enc  = 1'b0;
        load_m_skid = 1'b0;
        load_s      = 1'b0;
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    load_m_enc = 1'b1;
                    state_nxt  = ONE;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    load_m_enc = 1'b1;
                end else if (in_fire) begin
                    load_s    = 1'b1;
                    state_nxt = FULL;
                end else if (out_fire) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    load_m_skid = 1'b1;
                    state_nxt   = ONE;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // Ready is computed from next state so it is a plain flop with no path from i_out_rdy.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            in_rdy_q <= 1'b1;
        end else begin
            state    <= state_nxt;
            in_rdy_q <= (state_nxt != FULL);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_idx  <= '0;
            m_zero <= 1'b0;
            s_idx  <= '0;
            s_zero <= 1'b0;
        end else begin
            if (load_m_enc) begin
                m_idx  <= enc_idx;
                m_zero <= enc_zero;
            end else if (load_m_skid) begin
                m_idx  <= s_idx;
                m_zero <= s_zero;
            end
            if (load_s) begin
                s_idx  <= enc_idx;
                s_zero <= enc_zero;
            end
        end
    end

`ifdef OH_ENC_PIPE_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            m_err <= 1'b0;
            s_err <= 1'b0;
        end else begin
            if (load_m_enc)       m_err <= enc_err;
            else if (load_m_skid) m_err <= s_err;
            if (load_s)           s_err <= enc_err;
        end
    end

    assign o_out_err = m_err;
`endif

    assign o_in_rdy   = in_rdy_q;
    assign o_out_vld  = (state != EMPTY);
    assign o_out_idx  = m_idx;
    assign o_out_zero = m_zero;

endmodule

// File: tb/tb_oh_enc_pipe.sv
// tb/tb_oh_enc_pipe.sv - table and scoreboard bench for oh_enc_pipe at W=16
module tb_oh_enc_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_in_vld = 1'b0;
    logic [15:0] i_in_x = '0;
    logic        o_in_rdy;
    logic        o_out_vld;
    logic [3:0]  o_out_idx;
    logic        o_out_zero;
`ifdef OH_ENC_PIPE_CHECK_EN
    logic        o_out_err;
`endif
    logic        i_out_rdy = 1'b1;

    oh_enc_pipe #(.W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_in_vld   (i_in_vld),
        .i_in_x     (i_in_x),
        .o_in_rdy   (o_in_rdy),
        .o_out_vld  (o_out_vld),
        .o_out_idx  (o_out_idx),
        .o_out_zero (o_out_zero),
`ifdef OH_ENC_PIPE_CHECK_EN
        .o_out_err  (o_out_err),
`endif
        .i_out_rdy  (i_out_rdy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] idx;
        logic       zero;
        logic       err;
    } exp_t;

    typedef struct {
        logic [15:0] x;
        logic [3:0]  idx;
        logic        zero;
        logic        err;
    } vec_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_pops   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [15:0] x);
        exp_t r;
        int   cnt;
        cnt    = 0;
        r.idx  = '0;
        r.zero = 1'b1;
        r.err  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (x[i]) begin
                r.idx  = 4'(i);
                r.zero = 1'b0;
                cnt++;
            end
        end
        r.err = (cnt > 1);
        return r;
    endfunction

    // Inputs are stable here (1 time unit after the previous edge); score the
    // handshakes that the coming edge will complete, then advance one cycle.
    task automatic step();
        bit   in_f, out_f;
        exp_t e;
        if (rst) begin
            sb.delete();
        end else begin
            in_f  = i_in_vld && o_in_rdy;
            out_f = o_out_vld && i_out_rdy;
            if (out_f) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_underflow: output idx %0d fired, expected nothing", o_out_idx);
                end else begin
                    e = sb.pop_front();
                    n_pops++;
                    check("sb_idx", 32'(o_out_idx), 32'(e.idx));
                    check("sb_zero", 32'(o_out_zero), 32'(e.zero));
`ifdef OH_ENC_PIPE_CHECK_EN
                    check("sb_err", 32'(o_out_err), 32'(e.err));
`endif
                end
            end
            if (in_f) sb.push_back(model(i_in_x));
        end
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[7];
    int   pops0;

    initial begin
        vecs[0] = '{16'h0400, 4'd10, 1'b0, 1'b0};
        vecs[1] = '{16'h0000, 4'd0,  1'b1, 1'b0};
        vecs[2] = '{16'h8001, 4'd15, 1'b0, 1'b1};
        vecs[3] = '{16'h0001, 4'd0,  1'b0, 1'b0};
        vecs[4] = '{16'h8000, 4'd15, 1'b0, 1'b0};
        vecs[5] = '{16'h00f0, 4'd7,  1'b0, 1'b1};
        vecs[6] = '{16'h0002, 4'd1,  1'b0, 1'b0};

        // Reset held two cycles with valid asserted
        rst      = 1'b1;
        i_in_vld = 1'b1;
        i_in_x   = 16'h0400;
        for (int c = 0; c < 2; c++) begin
            step();
            check("rst_vld", 32'(o_out_vld), 32'd0);
            check("rst_rdy", 32'(o_in_rdy), 32'd1);
            check("rst_idx", 32'(o_out_idx), 32'd0);
            check("rst_zero", 32'(o_out_zero), 32'd0);
        end
        rst      = 1'b0;
        i_in_vld = 1'b0;
        step();
        check("idle_vld", 32'(o_out_vld), 32'd0);

        // Table: each vector accepted, visible next cycle, then drained
        i_out_rdy = 1'b1;
        for (int v = 0; v < 7; v++) begin
            i_in_vld = 1'b1;
            i_in_x   = vecs[v].x;
            step();
            i_in_vld = 1'b0;
            i_in_x   = 16'hffff;
            check("tbl_vld", 32'(o_out_vld), 32'd1);
            check("tbl_idx", 32'(o_out_idx), 32'(vecs[v].idx));
            check("tbl_zero", 32'(o_out_zero), 32'(vecs[v].zero));
`ifdef OH_ENC_PIPE_CHECK_EN
            check("tbl_err", 32'(o_out_err), 32'(vecs[v].err));
`endif
            step();
            check("tbl_drain_vld", 32'(o_out_vld), 32'd0);
        end

        // Backpressure: fill M and S, third held at input
        i_out_rdy = 1'b0;
        i_in_vld  = 1'b1;
        i_in_x    = 16'h0001;
        step();
        check("bp_rdy_one", 32'(o_in_rdy), 32'd1);
        i_in_x = 16'h0002;
        step();
        check("bp_rdy_full", 32'(o_in_rdy), 32'd0);
        i_in_x = 16'h0004;
        step();
        check("bp_rdy_held", 32'(o_in_rdy), 32'd0);
        check("bp_idx_stable", 32'(o_out_idx), 32'd0);
        check("bp_vld_stable", 32'(o_out_vld), 32'd1);
        i_out_rdy = 1'b1;
        step();
        check("bp_rdy_rise", 32'(o_in_rdy), 32'd1);
        check("bp_idx1", 32'(o_out_idx), 32'd1);
        step();
        i_in_vld = 1'b0;
        check("bp_idx2", 32'(o_out_idx), 32'd2);
        check("bp_vld2", 32'(o_out_vld), 32'd1);
        step();
        check("bp_empty", 32'(o_out_vld), 32'd0);
        check("bp_sb_empty", 32'(sb.size()), 32'd0);

        // Streaming: 64 random one-hot vectors, no bubbles
        pops0     = n_pops;
        i_out_rdy = 1'b1;
        for (int k = 0; k < 64; k++) begin
            i_in_vld = 1'b1;
            i_in_x   = 16'h0001 << $urandom_range(0, 15);
            step();
            check("stream_vld", 32'(o_out_vld), 32'd1);
            check("stream_rdy", 32'(o_in_rdy), 32'd1);
        end
        i_in_vld = 1'b0;
        step();
        check("stream_count", 32'(n_pops - pops0), 32'd64);
        check("stream_sb_empty", 32'(sb.size()), 32'd0);

        // Reset mid-operation from FULL, with a handshake offered in the reset cycle
        i_out_rdy = 1'b0;
        i_in_vld  = 1'b1;
        i_in_x    = 16'h0100;
        step();
        i_in_x = 16'h0200;
        step();
        check("mrst_full", 32'(o_in_rdy), 32'd0);
        rst       = 1'b1;
        i_out_rdy = 1'b1;
        i_in_x    = 16'h4000;
        step();
        check("mrst_vld", 32'(o_out_vld), 32'd0);
        check("mrst_rdy", 32'(o_in_rdy), 32'd1);
        rst      = 1'b0;
        i_in_vld = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            check("mrst_no_stale", 32'(o_out_vld), 32'd0);
        end
        i_in_vld = 1'b1;
        i_in_x   = 16'h0008;
        step();
        i_in_vld = 1'b0;
        check("mrst_new_idx", 32'(o_out_idx), 32'd3);
        step();
        check("mrst_done", 32'(o_out_vld), 32'd0);
        check("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
